// File: rtl/alu_pkg.sv
// Shared command/error encodings and sequencer state type for the ALU front end.
// Combinational helpers only; no state lives here.
package alu_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_MUL = 4'd3;
    localparam logic [3:0] CMD_DIV = 4'd4;
    localparam logic [3:0] CMD_MOD = 4'd5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_DBZ  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    function automatic logic cmd_legal(input logic [3:0] cmd);
        return (cmd >= CMD_ADD) && (cmd <= CMD_MOD);
    endfunction

    function automatic logic cmd_is_div(input logic [3:0] cmd);
        return (cmd == CMD_DIV) || (cmd == CMD_MOD);
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable settle-latency down-counter; done flags the cycle it reaches zero.
// Latency: load takes effect next edge; no handshake, load has priority over count.
// Backpressure: none, free-running while nonzero.
module alu_lat_counter #(
    parameter int MAX_LAT = 8,
    parameter int CW      = $clog2(MAX_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The edge that sees 1 moves the count to 0; a load of 0 expires at once.
    assign done = (cnt <= CW'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU front end: registers a request onto the ALU, waits the op's settle latency, captures the result.
// Latency: accept to rsp_valid is LAT+1 cycles (1 cycle for illegal/divide-by-zero); optional stats via ALU_SEQ_STATS_EN.
// Backpressure: rsp_valid holds until rsp_ready; req_ready only in IDLE, so one op in flight with a 1-cycle bubble.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RES_W   = 32,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cmd,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_cmd,
    input  logic [RES_W-1:0]  alu_result,
    input  logic [1:0]        alu_error,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic [1:0]        rsp_error,
    output logic [RES_W-1:0]  acc,
    output logic              busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_errs
`endif
);

    localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    seq_state_t        state, state_nxt;
    logic              ld_alu, ld_err, cap, clr_cmd, cnt_done;
    logic [1:0]        err_code;
    logic [CW-1:0]     lat_val;
    logic [DATA_W-1:0] a_sel;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign a_sel     = req_use_acc ? acc[DATA_W-1:0] : req_a;

    always_comb begin
        lat_val = CW'(ADD_LAT);
        case (req_cmd)
            CMD_MUL:          lat_val = CW'(MUL_LAT);
            CMD_DIV, CMD_MOD: lat_val = CW'(DIV_LAT);
            default:          ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_alu    = 1'b0;
        ld_err    = 1'b0;
        err_code  = ERR_NONE;
        cap       = 1'b0;
        clr_cmd   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!cmd_legal(req_cmd)) begin
                        ld_err    = 1'b1;
                        err_code  = ERR_ILL;
                        state_nxt = RESP;
                    end else if (cmd_is_div(req_cmd) && (req_b == '0)) begin
                        // Never present a zero divisor to the ALU.
                        ld_err    = 1'b1;
                        err_code  = ERR_DBZ;
                        state_nxt = RESP;
                    end else begin
                        ld_alu    = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_done) begin
                    cap       = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    clr_cmd   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    alu_lat_counter #(.MAX_LAT(MAX_LAT), .CW(CW)) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld_alu),
        .load_val (lat_val),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cmd    <= CMD_NOP;
            rsp_result <= '0;
            rsp_error  <= ERR_NONE;
            acc        <= '0;
        end else begin
            if (ld_alu) begin
                alu_a   <= a_sel;
                alu_b   <= req_b;
                alu_cmd <= req_cmd;
            end else if (clr_cmd) begin
                alu_cmd <= CMD_NOP;
            end
            if (ld_err) begin
                rsp_result <= '0;
                rsp_error  <= err_code;
            end
            if (cap) begin
                rsp_result <= alu_result;
                rsp_error  <= alu_error;
                acc        <= alu_result;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic rsp_hs;
    assign rsp_hs = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (rsp_hs) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if ((rsp_error != ERR_NONE) && (stat_errs != 16'hFFFF))
                stat_errs <= stat_errs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, table-driven ops with a response scoreboard,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_use_acc;
    logic [3:0]  req_cmd;
    logic [15:0] req_a, req_b;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_result;
    logic [1:0]  alu_error;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result, acc;
    logic [1:0]  rsp_error;
    logic        busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_errs;
`endif

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_use_acc (req_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cmd     (alu_cmd),
        .alu_result  (alu_result),
        .alu_error   (alu_error),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .acc         (acc),
        .busy        (busy)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_ops    (stat_ops),
        .stat_errs   (stat_errs)
`endif
    );

    // Signed 16-bit ALU with 32-bit sign-extended result.
    logic signed [16:0] sum17;
    logic signed [31:0] sa32, sb32;
    always_comb begin
        alu_result = '0;
        alu_error  = 2'b00;
        sum17      = '0;
        sa32       = {{16{alu_a[15]}}, alu_a};
        sb32       = {{16{alu_b[15]}}, alu_b};
        case (alu_cmd)
            4'd1, 4'd2: begin
                if (alu_cmd == 4'd1) sum17 = $signed({alu_a[15], alu_a}) + $signed({alu_b[15], alu_b});
                else                 sum17 = $signed({alu_a[15], alu_a}) - $signed({alu_b[15], alu_b});
                alu_result = {{15{sum17[16]}}, sum17};
                alu_error  = {1'b0, sum17[16] != sum17[15]};
            end
            4'd3: alu_result = sa32 * sb32;
            4'd4: if (alu_b == 16'd0) alu_error = 2'b10; else alu_result = sa32 / sb32;
            4'd5: if (alu_b == 16'd0) alu_error = 2'b10; else alu_result = sa32 % sb32;
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hs_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_cnt = 0;
            hs_err = 0;
        end else if (rsp_valid && rsp_ready) begin
            hs_cnt = hs_cnt + 1;
            if (rsp_error != 2'b00) hs_err = hs_err + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic        use_acc;
        logic        to_alu;
        logic [15:0] exp_a;
        logic [31:0] exp_res;
        logic [1:0]  exp_err;
        logic [31:0] exp_acc;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
        logic [31:0] acc;
        int          lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sbq[$];

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_op(input int idx, input vec_t v);
        exp_t e;
        int   lat;
        logic nz;
        @(negedge clk);
        req_valid   = 1'b1;
        req_cmd     = v.cmd;
        req_a       = v.a;
        req_b       = v.b;
        req_use_acc = v.use_acc;
        rsp_ready   = 1'b1;
        sbq.push_back('{res: v.exp_res, err: v.exp_err, acc: v.exp_acc, lat: v.exp_lat});
        wait_ready($sformatf("v%0d", idx));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        nz  = (alu_cmd != 4'd0);
        if (v.to_alu) begin
            chk($sformatf("v%0d_alu_a", idx), 32'(alu_a), 32'(v.exp_a));
            chk($sformatf("v%0d_alu_b", idx), 32'(alu_b), 32'(v.b));
            chk($sformatf("v%0d_alu_cmd", idx), 32'(alu_cmd), 32'(v.cmd));
        end
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
            nz = nz | (alu_cmd != 4'd0);
        end
        e = sbq.pop_front();
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.lat));
        chk($sformatf("v%0d_result", idx), rsp_result, e.res);
        chk($sformatf("v%0d_error", idx), 32'(rsp_error), 32'(e.err));
        chk($sformatf("v%0d_acc", idx), acc, e.acc);
        if (!v.to_alu) chk($sformatf("v%0d_alu_idle", idx), 32'(nz), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   hs0;
        int   n;
        logic seen;

        //          cmd    a       b      uacc alu  exp_a    exp_res          err    exp_acc          lat
        vecs[0]  = '{4'd1, 16'd249,   16'd0,    1'b0, 1'b1, 16'd249,   32'd249,        2'b00, 32'd249,        2};
        vecs[1]  = '{4'd3, 16'd32000, 16'd8193, 1'b0, 1'b1, 16'd32000, 32'd262176000,  2'b00, 32'd262176000,  5};
        vecs[2]  = '{4'd4, 16'd249,   16'd0,    1'b0, 1'b0, 16'd0,     32'd0,          2'b10, 32'd262176000,  1};
        vecs[3]  = '{4'd7, 16'd1,     16'd2,    1'b0, 1'b0, 16'd0,     32'd0,          2'b11, 32'd262176000,  1};
        vecs[4]  = '{4'd1, 16'd32000, 16'd8193, 1'b0, 1'b1, 16'd32000, 32'd40193,      2'b01, 32'd40193,      2};
        vecs[5]  = '{4'd3, 16'd10,    16'd3,    1'b0, 1'b1, 16'd10,    32'd30,         2'b00, 32'd30,         5};
        vecs[6]  = '{4'd2, 16'd999,   16'd5,    1'b1, 1'b1, 16'd30,    32'd25,         2'b00, 32'd25,         2};
        vecs[7]  = '{4'd4, 16'd100,   16'd7,    1'b0, 1'b1, 16'd100,   32'd14,         2'b00, 32'd14,         9};
        vecs[8]  = '{4'd5, 16'd100,   16'd7,    1'b0, 1'b1, 16'd100,   32'd2,          2'b00, 32'd2,          9};
        vecs[9]  = '{4'd2, 16'd5,     16'd9,    1'b0, 1'b1, 16'd5,     32'hFFFFFFFC,   2'b00, 32'hFFFFFFFC,   2};
        vecs[10] = '{4'd1, 16'd0,     16'd10,   1'b1, 1'b1, 16'hFFFC,  32'd6,          2'b00, 32'd6,          2};
        vecs[11] = '{4'd5, 16'd5,     16'd0,    1'b0, 1'b0, 16'd0,     32'd0,          2'b10, 32'd6,          1};

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_cmd     = 4'd0;
        req_a       = 16'd0;
        req_b       = 16'd0;
        req_use_acc = 1'b0;
        rsp_ready   = 1'b1;
        #12;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_acc", acc, 32'd0);
        chk("reset_alu_cmd", 32'(alu_cmd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) do_op(i, vecs[i]);

        // Backpressure: response held 5 cycles while a second request waits.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 4'd1; req_a = 16'd7; req_b = 16'd8; req_use_acc = 1'b0;
        rsp_ready = 1'b0;
        wait_ready("bp");
        @(posedge clk);
        @(negedge clk);
        req_cmd = 4'd3; req_a = 16'd3; req_b = 16'd4;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        hs0 = hs_cnt;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_hold%0d_result", k), rsp_result, 32'd15);
            chk($sformatf("bp_hold%0d_error", k), 32'(rsp_error), 32'd0);
            chk($sformatf("bp_hold%0d_req_ready", k), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_one_handshake", 32'(hs_cnt), 32'(hs0 + 1));
        chk("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_held_accepted_busy", 32'(busy), 32'd1);
        chk("bp_held_alu_cmd", 32'(alu_cmd), 32'd3);
        chk("bp_held_alu_a", 32'(alu_a), 32'd3);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_held_result", rsp_result, 32'd12);
        chk("bp_held_acc", acc, 32'd12);

        // Reset asserted in the middle of a multiply.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 4'd3; req_a = 16'd100; req_b = 16'd200;
        wait_ready("rst");
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_alu_cmd", 32'(alu_cmd), 32'd0);
        chk("rst_mid_alu_a", 32'(alu_a), 32'd0);
        chk("rst_mid_alu_b", 32'(alu_b), 32'd0);
        chk("rst_mid_acc", acc, 32'd0);
        chk("rst_mid_result", rsp_result, 32'd0);
        chk("rst_mid_error", 32'(rsp_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hs0  = hs_cnt;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("rst_no_response", 32'(seen), 32'd0);
        chk("rst_no_handshake", 32'(hs_cnt), 32'(hs0));

`ifdef ALU_SEQ_STATS_EN
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 4'd9; req_a = 16'd0; req_b = 16'd0;
        wait_ready("stat");
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("stat_ops", 32'(stat_ops), 32'd1);
        chk("stat_errs", 32'(stat_errs), 32'd1);
        chk("stat_errs_model", 32'(stat_errs), 32'(hs_err));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
